// File: rtl/serial_mult_ctrl_n_pkg.sv
// Shared types for the serial shift-add multiplier: controller state encoding.
package serial_mult_ctrl_n_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StConv = 3'd1,
        StMult = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/serial_mult_ctrl_n_shift_add_core.sv
// Shift-add multiply datapath: magnitude conversion, one partial product per step,
// sign correction of the accumulated product.
module serial_mult_ctrl_n_shift_add_core #(
    parameter int unsigned W = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           step_i,
    input  logic                           finish_i,
    input  logic                           signed_i,
    input  logic [W-1:0]                   x_i,
    input  logic [W-1:0]                   y_i,
    input  logic [$clog2(2*W+1)-1:0]       cnt_i,
    output logic [2*W-1:0]                 prod_o,
    output logic [2*W-1:0]                 z_o
);

    localparam int unsigned PW = 2 * W;

    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [PW-1:0] p_q, p_d, z_q, z_d;
    logic          neg_q, neg_d;
    logic          x_neg, y_neg;

    assign x_neg  = signed_i & x_i[W-1];
    assign y_neg  = signed_i & y_i[W-1];
    // -0 cannot arise: negating a zero accumulator yields zero.
    assign prod_o = neg_q ? (~p_q + PW'(1)) : p_q;
    assign z_o    = z_q;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        p_d   = p_q;
        neg_d = neg_q;
        z_d   = z_q;
        if (start_i) begin
            // |-2^(W-1)| = 2^(W-1) still fits as a W-bit unsigned magnitude.
            a_d   = x_neg ? (~x_i + W'(1)) : x_i;
            b_d   = y_neg ? (~y_i + W'(1)) : y_i;
            p_d   = '0;
            neg_d = x_neg ^ y_neg;
        end else if (step_i) begin
            if (b_q[0]) begin
                p_d = p_q + (PW'(a_q) << cnt_i);
            end
            b_d = b_q >> 1;
        end
        if (finish_i) begin
            z_d = prod_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            p_q   <= '0;
            neg_q <= 1'b0;
            z_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            p_q   <= p_d;
            neg_q <= neg_d;
            z_q   <= z_d;
        end
    end

endmodule

// File: rtl/serial_mult_ctrl_n.sv
// Serial-load / serial-unload W-bit signed/unsigned multiplier controller.
// One FSM sequences operand load, conversion, W multiply steps, sign fix and unload.
module serial_mult_ctrl_n
    import serial_mult_ctrl_n_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_in,
    input  logic           sx,
    input  logic           y_in,
    input  logic           sy,
    input  logic           signed_mode,
    input  logic           mul,
    input  logic           sz,
    output logic           fx,
    output logic           fy,
    output logic           busy,
    output logic           done,
    output logic           z_out,
    output logic           fz,
    output logic [W-1:0]   x_test,
    output logic [W-1:0]   y_test,
    output logic [2*W-1:0] z_test
);

    localparam int unsigned CNT_W = $clog2(2 * W + 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(W);
    localparam logic [CNT_W-1:0] LastMul = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] LastOut = CNT_W'(2 * W - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       x_q, x_d, y_q, y_d;
    logic [CNT_W-1:0]   xcnt_q, xcnt_d, ycnt_q, ycnt_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d, ocnt_q, ocnt_d;
    logic [2*W-1:0]     zsh_q, zsh_d;
    logic               smode_q, smode_d;
    logic               fz_q, fz_d;
    logic               core_start, core_step, core_finish;
    logic [2*W-1:0]     core_prod;

    assign fx     = (xcnt_q == FullCnt);
    assign fy     = (ycnt_q == FullCnt);
    assign busy   = (state_q == StConv) || (state_q == StMult) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign z_out  = done & zsh_q[2*W-1];
    assign fz     = fz_q;
    assign x_test = x_q;
    assign y_test = y_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xcnt_d      = xcnt_q;
        ycnt_d      = ycnt_q;
        mcnt_d      = mcnt_q;
        ocnt_d      = ocnt_q;
        zsh_d       = zsh_q;
        smode_d     = smode_q;
        fz_d        = 1'b0;
        core_start  = 1'b0;
        core_step   = 1'b0;
        core_finish = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sx && !fx) begin
                    x_d    = {x_q[W-2:0], x_in};
                    xcnt_d = xcnt_q + 1'b1;
                end
                if (sy && !fy) begin
                    y_d    = {y_q[W-2:0], y_in};
                    ycnt_d = ycnt_q + 1'b1;
                end
                if (mul && fx && fy) begin
                    state_d = StConv;
                    smode_d = signed_mode;
                end
            end
            StConv: begin
                core_start = 1'b1;
                mcnt_d     = '0;
                state_d    = StMult;
            end
            StMult: begin
                core_step = 1'b1;
                mcnt_d    = mcnt_q + 1'b1;
                if (mcnt_q == LastMul) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                core_finish = 1'b1;
                zsh_d       = core_prod;
                ocnt_d      = '0;
                state_d     = StDone;
            end
            StDone: begin
                if (sz) begin
                    zsh_d  = zsh_q << 1;
                    ocnt_d = ocnt_q + 1'b1;
                    if (ocnt_q == LastOut) begin
                        state_d = StIdle;
                        fz_d    = 1'b1;
                        xcnt_d  = '0;
                        ycnt_d  = '0;
                        ocnt_d  = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            xcnt_q  <= '0;
            ycnt_q  <= '0;
            mcnt_q  <= '0;
            ocnt_q  <= '0;
            zsh_q   <= '0;
            smode_q <= 1'b0;
            fz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xcnt_q  <= xcnt_d;
            ycnt_q  <= ycnt_d;
            mcnt_q  <= mcnt_d;
            ocnt_q  <= ocnt_d;
            zsh_q   <= zsh_d;
            smode_q <= smode_d;
            fz_q    <= fz_d;
        end
    end

    serial_mult_ctrl_n_shift_add_core #(
        .W (W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start_i  (core_start),
        .step_i   (core_step),
        .finish_i (core_finish),
        .signed_i (smode_q),
        .x_i      (x_q),
        .y_i      (y_q),
        .cnt_i    (mcnt_q),
        .prod_o   (core_prod),
        .z_o      (z_test)
    );

endmodule
